// File: rtl/timed_decoder_pkg.sv
// Shared definitions for the timed 3-to-8 decoder: state encoding, widths and
// the code/line mapping used by both the encoder and the decoder.
package timed_decoder_pkg;

  localparam int CODE_W = 3;
  localparam int LINE_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_DRIVE = ST_DRIVE,
    S_GAP   = ST_GAP
  } state_e;

  // Code n selects line n (code 0 -> dout_a ... code 7 -> dout_h).
  function automatic logic [LINE_W-1:0] code_to_line(input logic [CODE_W-1:0] code);
    code_to_line = LINE_W'(1) << code;
  endfunction

  // Inverse mapping for the encoder side; the lowest set line wins.
  function automatic logic [CODE_W-1:0] line_to_code(input logic [LINE_W-1:0] line);
    line_to_code = '0;
    for (int i = LINE_W - 1; i >= 0; i--) begin
      if (line[i]) line_to_code = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/timed_decoder_if.sv
// Code handshake and decoded line bundle between a code source and the decoder.
interface timed_decoder_if;

  logic din_valid;
  logic din_0;
  logic din_1;
  logic din_2;
  logic din_ready;
  logic dout_a;
  logic dout_b;
  logic dout_c;
  logic dout_d;
  logic dout_e;
  logic dout_f;
  logic dout_g;
  logic dout_h;
  logic dout_valid;
  logic busy;

  modport master (
    output din_valid, din_0, din_1, din_2,
    input  din_ready, dout_a, dout_b, dout_c, dout_d,
    input  dout_e, dout_f, dout_g, dout_h, dout_valid, busy
  );

  modport slave (
    input  din_valid, din_0, din_1, din_2,
    output din_ready, dout_a, dout_b, dout_c, dout_d,
    output dout_e, dout_f, dout_g, dout_h, dout_valid, busy
  );

endinterface

// File: rtl/timed_decoder_decoder_3to8.sv
// Combinational 3-bit code to one-hot line decoder with enable.
module decoder_3to8
  import timed_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              en,
  output logic [LINE_W-1:0] line
);

  assign line = en ? code_to_line(code) : '0;

endmodule

// File: rtl/timed_decoder.sv
// Registered 3-to-8 decoder: drives the decoded line for HOLD_CYC cycles,
// then holds all lines low for GAP_CYC cycles before accepting the next code.
module timed_decoder
  import timed_decoder_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 1,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  timed_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LD = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.din_valid && ready_q) begin
          code_d  = {bus.din_2, bus.din_1, bus.din_0};
          cnt_d   = HOLD_LD;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          if (GAP_CYC > 0) begin
            cnt_d   = GAP_LD;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so the line rises on the
    // handshake edge itself rather than one cycle later.
    valid_d = (state_d == S_DRIVE);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  decoder_3to8 u_dec (
    .code (code_d),
    .en   (state_d == S_DRIVE),
    .line (line_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.din_ready  = ready_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign {bus.dout_h, bus.dout_g, bus.dout_f, bus.dout_e,
          bus.dout_d, bus.dout_c, bus.dout_b, bus.dout_a} = line_q;

endmodule

// File: tb/tb_timed_decoder.sv
// Self-checking bench for timed_decoder: three parameter sets checked against a
// window-timing reference model (accept cycle, hold length, gap length).
module tb_timed_decoder;
  import timed_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       vld  [3];
  logic [2:0] code [3];
  logic [7:0] obs_line  [3];
  logic       obs_valid [3];
  logic       obs_busy  [3];
  logic       obs_ready [3];

  timed_decoder_if u_if0 ();
  timed_decoder_if u_if1 ();
  timed_decoder_if u_if2 ();

  timed_decoder #(.HOLD_CYC(4),   .GAP_CYC(1), .CNT_W(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0.slave));
  timed_decoder #(.HOLD_CYC(0),   .GAP_CYC(0), .CNT_W(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));
  timed_decoder #(.HOLD_CYC(255), .GAP_CYC(1), .CNT_W(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2.slave));

  assign u_if0.din_valid = vld[0];
  assign {u_if0.din_2, u_if0.din_1, u_if0.din_0} = code[0];
  assign u_if1.din_valid = vld[1];
  assign {u_if1.din_2, u_if1.din_1, u_if1.din_0} = code[1];
  assign u_if2.din_valid = vld[2];
  assign {u_if2.din_2, u_if2.din_1, u_if2.din_0} = code[2];

  assign obs_line[0] = {u_if0.dout_h, u_if0.dout_g, u_if0.dout_f, u_if0.dout_e,
                        u_if0.dout_d, u_if0.dout_c, u_if0.dout_b, u_if0.dout_a};
  assign obs_line[1] = {u_if1.dout_h, u_if1.dout_g, u_if1.dout_f, u_if1.dout_e,
                        u_if1.dout_d, u_if1.dout_c, u_if1.dout_b, u_if1.dout_a};
  assign obs_line[2] = {u_if2.dout_h, u_if2.dout_g, u_if2.dout_f, u_if2.dout_e,
                        u_if2.dout_d, u_if2.dout_c, u_if2.dout_b, u_if2.dout_a};
  assign obs_valid[0] = u_if0.dout_valid;
  assign obs_valid[1] = u_if1.dout_valid;
  assign obs_valid[2] = u_if2.dout_valid;
  assign obs_busy[0]  = u_if0.busy;
  assign obs_busy[1]  = u_if1.busy;
  assign obs_busy[2]  = u_if2.busy;
  assign obs_ready[0] = u_if0.din_ready;
  assign obs_ready[1] = u_if1.din_ready;
  assign obs_ready[2] = u_if2.din_ready;

  // Reference model: each DUT is described only by the cycle its last code was
  // accepted and that code; everything else follows from hold/gap arithmetic.
  int         cyc = 0;
  int         st    [3];
  logic [2:0] mcode [3];

  function automatic int hold_par(int d);
    return (d == 0) ? 4 : (d == 1) ? 0 : 255;
  endfunction

  function automatic int gap_par(int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic int heff(int d);
    return (hold_par(d) > 0) ? hold_par(d) : 1;
  endfunction

  function automatic logic [7:0] exp_line(int d);
    if (cyc >= st[d] && cyc < st[d] + heff(d)) return 8'(1) << mcode[d];
    return 8'h00;
  endfunction

  function automatic logic exp_ready(int d);
    return cyc >= st[d] + heff(d) + gap_par(d);
  endfunction

  function automatic logic [10:0] exp_stat(int d);
    return {exp_line(d), exp_line(d) != 8'h00, !exp_ready(d), exp_ready(d)};
  endfunction

  function automatic logic [10:0] obs_stat(int d);
    return {obs_line[d], obs_valid[d], obs_busy[d], obs_ready[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      st[d]    = -100000;
      mcode[d] = 3'd0;
    end
  endtask

  // One clock: handshake decisions use the model's ready from before the edge.
  task automatic tick();
    logic pre [3];
    for (int d = 0; d < 3; d++) pre[d] = exp_ready(d);
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (vld[d] && pre[d]) begin
        st[d]    = cyc;
        mcode[d] = code[d];
      end
    end
    #1;
  endtask

  task automatic wait_model_idle(int d);
    for (int k = 0; k < 300 && !exp_ready(d); k++) tick();
  endtask

  task automatic test_reset();
    bit acc;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_stat(d) !== 11'b00000000_001) begin
        errors++;
        $display("FAIL reset_idle dut%0d: got %b expected %b", d, obs_stat(d), 11'b00000000_001);
      end
    end
    code[0] = 3'd5;
    vld[0]  = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      tick();
      acc = (st[0] == cyc);
    end
    vld[0] = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL reset_accept dut0: no handshake within 20 cycles, expected one");
    end
    tick();
    checks++;
    if (obs_stat(0) !== 11'b00100000_110) begin
      errors++;
      $display("FAIL reset_pre_drive dut0: got %b expected %b", obs_stat(0), 11'b00100000_110);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_stat(0) !== 11'b00000000_001) begin
      errors++;
      $display("FAIL reset_async dut0: got %b expected %b", obs_stat(0), 11'b00000000_001);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_stat(d) !== 11'b00000000_001) begin
          errors++;
          $display("FAIL reset_after dut%0d: got %b expected %b", d, obs_stat(d), 11'b00000000_001);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int acc_cyc [8];
    int hi_cnt  [8];
    bit acc;
    for (int i = 0; i < 8; i++) hi_cnt[i] = 0;
    wait_model_idle(0);
    for (int c = 0; c < 8; c++) begin
      code[0] = 3'(c);
      vld[0]  = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        tick();
        checks++;
        if (obs_stat(0) !== exp_stat(0)) begin
          errors++;
          $display("FAIL sweep_state code%0d: got %b expected %b", c, obs_stat(0), exp_stat(0));
        end
        for (int i = 0; i < 8; i++) hi_cnt[i] += int'(obs_line[0][i]);
        acc = (st[0] == cyc);
      end
      acc_cyc[c] = cyc;
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL sweep_accept code%0d: no handshake within 20 cycles", c);
      end
    end
    vld[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (obs_stat(0) !== exp_stat(0)) begin
        errors++;
        $display("FAIL sweep_tail: got %b expected %b", obs_stat(0), exp_stat(0));
      end
      for (int i = 0; i < 8; i++) hi_cnt[i] += int'(obs_line[0][i]);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hi_cnt[i] != 4) begin
        errors++;
        $display("FAIL sweep_hold line%0d: high %0d cycles, expected 4", i, hi_cnt[i]);
      end
    end
    for (int c = 1; c < 8; c++) begin
      checks++;
      if (acc_cyc[c] - acc_cyc[c-1] != 6) begin
        errors++;
        $display("FAIL sweep_period code%0d: spacing %0d, expected 6", c, acc_cyc[c] - acc_cyc[c-1]);
      end
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] src;
    logic [2:0] enc;
    bit acc;
    for (int i = 0; i < 8; i++) begin
      src = 8'(1) << i;
      enc = 3'd0;
      for (int b = 0; b < 8; b++) if (src[b]) enc = 3'(b);
      code[0] = enc;
      vld[0]  = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        tick();
        acc = (st[0] == cyc);
      end
      vld[0] = 1'b0;
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL round_trip_accept line%0d: no handshake within 20 cycles", i);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_line[0] !== src) begin
          errors++;
          $display("FAIL round_trip line%0d cyc%0d: got %b expected %b", i, k, obs_line[0], src);
        end
        if (k < 3) tick();
      end
    end
  endtask

  task automatic test_ignored();
    bit acc;
    bit prev;
    int c_hi, rises, g_seen;
    wait_model_idle(0);
    code[0] = 3'd2;
    vld[0]  = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      tick();
      acc = (st[0] == cyc);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL ignored_accept: no handshake within 20 cycles");
    end
    prev = 1'b0; c_hi = 0; rises = 0; g_seen = 0;
    for (int j = 0; j < 12; j++) begin
      checks++;
      if (obs_stat(0) !== exp_stat(0)) begin
        errors++;
        $display("FAIL ignored_state j%0d: got %b expected %b", j, obs_stat(0), exp_stat(0));
      end
      c_hi   += int'(obs_line[0][2]);
      g_seen += int'(obs_line[0][6]);
      if (obs_line[0][2] && !prev) rises++;
      prev = obs_line[0][2];
      if (j == 1) begin
        code[0] = 3'd6;
        vld[0]  = 1'b1;
      end else begin
        vld[0] = 1'b0;
      end
      tick();
    end
    checks++;
    if (c_hi != 4) begin
      errors++;
      $display("FAIL ignored_hold: dout_c high %0d cycles, expected 4", c_hi);
    end
    checks++;
    if (rises != 1 || g_seen != 0) begin
      errors++;
      $display("FAIL ignored_extra: dout_c windows %0d dout_g cycles %0d, expected 1 and 0", rises, g_seen);
    end
  endtask

  task automatic test_param_edges();
    bit acc;
    int hi;
    logic [2:0] r;
    wait_model_idle(1);
    code[1] = 3'd3;
    vld[1]  = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      tick();
      acc = (st[1] == cyc);
    end
    checks++;
    if (!acc || obs_line[1] !== 8'h08 || obs_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL edge_h0_drive: line %b valid %b, expected 00001000 1", obs_line[1], obs_valid[1]);
    end
    code[1] = 3'd5;
    tick();
    checks++;
    if (obs_line[1] !== 8'h00 || obs_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL edge_h0_release: line %b ready %b, expected 00000000 1", obs_line[1], obs_ready[1]);
    end
    tick();
    vld[1] = 1'b0;
    checks++;
    if (obs_line[1] !== 8'h20) begin
      errors++;
      $display("FAIL edge_h0_next: line %b, expected 00100000", obs_line[1]);
    end
    tick();
    checks++;
    if (obs_line[1] !== 8'h00) begin
      errors++;
      $display("FAIL edge_h0_single: line %b, expected 00000000", obs_line[1]);
    end

    wait_model_idle(2);
    r = 3'($urandom_range(0, 7));
    code[2] = r;
    vld[2]  = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      tick();
      acc = (st[2] == cyc);
    end
    vld[2] = 1'b0;
    hi = 0;
    for (int k = 0; k < 262; k++) begin
      hi += int'(obs_line[2][r]);
      if (obs_stat(2) !== exp_stat(2)) begin
        checks++;
        errors++;
        $display("FAIL edge_h255_state k%0d: got %b expected %b", k, obs_stat(2), exp_stat(2));
      end
      tick();
    end
    checks++;
    if (!acc || hi != 255) begin
      errors++;
      $display("FAIL edge_h255_hold: line%0d high %0d cycles, expected 255", r, hi);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      for (int d = 0; d < 3; d++) begin
        vld[d]  = ($urandom_range(0, 3) != 0);
        code[d] = 3'($urandom_range(0, 7));
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_stat(d) !== exp_stat(d)) begin
          errors++;
          $display("FAIL random_state dut%0d k%0d: got %b expected %b", d, k, obs_stat(d), exp_stat(d));
        end
        checks++;
        if ($countones(obs_line[d]) > 1 || obs_valid[d] !== (|obs_line[d])
            || obs_ready[d] !== !obs_busy[d]) begin
          errors++;
          $display("FAIL random_invariant dut%0d k%0d: line %b valid %b ready %b busy %b, expected onehot0 valid=|line ready=!busy",
                   d, k, obs_line[d], obs_valid[d], obs_ready[d], obs_busy[d]);
        end
      end
    end
    for (int d = 0; d < 3; d++) vld[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      vld[d]  = 1'b0;
      code[d] = 3'd0;
    end
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset();
    test_sweep();
    test_round_trip();
    test_ignored();
    test_param_edges();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
